alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one external combinational ALU between two requesters. Grants are
// combinational and one-hot-or-zero; the result and flags of a granted
// operation are captured on the next posedge together with a per-requester
// valid strobe, so every accepted operation responds exactly one cycle later.
//
// Parameters
//   PRIO_MODE     1 = round-robin between ties, 0 = requester 0 wins ties
//                 unless requester 1 has lost STARVE_LIMIT cycles in a row
//   STARVE_LIMIT  lost-cycle count at which requester 1 is forced through
//
// Ports
//   CLK, RST                      clock, async active-high reset
//   stall                         freezes all state and blocks grants
//   req0/req1                     operation requests
//   port_a0/b0, port_a1/b1        operands of each requester
//   alu_op0/alu_op1               opcodes of each requester
//   gnt0/gnt1                     combinational accept strobes
//   rsp_valid0/rsp_valid1         registered result valid per requester
//   rsp_o, rsp_v, rsp_n, rsp_z    registered result and flags
//   alu_port_a/b, alu_alu_op      operands and opcode sent to the ALU
//   alu_port_o, alu_*_flag        result and flags returned by the ALU
module alu_arbiter #(
  parameter int PRIO_MODE    = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        stall,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] port_a0,
  input  logic [31:0] port_b0,
  input  logic [31:0] port_a1,
  input  logic [31:0] port_b1,
  input  logic [3:0]  alu_op0,
  input  logic [3:0]  alu_op1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rsp_valid0,
  output logic        rsp_valid1,
  output logic [31:0] rsp_o,
  output logic        rsp_v,
  output logic        rsp_n,
  output logic        rsp_z,
  output logic [31:0] alu_port_a,
  output logic [31:0] alu_port_b,
  output logic [3:0]  alu_alu_op,
  input  logic [31:0] alu_port_o,
  input  logic        alu_v_flag,
  input  logic        alu_n_flag,
  input  logic        alu_z_flag
);

  // A limit of zero would give a zero-width counter, so keep at least one bit.
  localparam int WAIT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] STARVE_MAX = WAIT_W'(STARVE_LIMIT);

  logic              lastWinner_q, lastWinner_d;
  logic [WAIT_W-1:0] wait1_q, wait1_d;
  logic              rspValid0_q, rspValid0_d;
  logic              rspValid1_q, rspValid1_d;
  logic [31:0]       rspData_q, rspData_d;
  logic              rspV_q, rspV_d;
  logic              rspN_q, rspN_d;
  logic              rspZ_q, rspZ_d;
  logic              grant0, grant1;

  // Grant decision. A lone request always wins; a tie is resolved either by
  // alternating against the last winner or by fixed priority with the
  // starvation override for requester 1. Reset and stall block every grant.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!stall && !RST) begin
      if (req0 && !req1) begin
        grant0 = 1'b1;
      end else if (req1 && !req0) begin
        grant1 = 1'b1;
      end else if (req0 && req1) begin
        if (PRIO_MODE != 0) begin
          grant0 = lastWinner_q;
          grant1 = !lastWinner_q;
        end else if (wait1_q == STARVE_MAX) begin
          grant1 = 1'b1;
        end else begin
          grant0 = 1'b1;
        end
      end
    end
  end

  assign gnt0 = grant0;
  assign gnt1 = grant1;

  // Steer the winner's operands to the shared ALU; idle cycles drive zeros
  // so the ALU inputs do not toggle with an ungranted requester.
  always_comb begin
    alu_port_a = 32'd0;
    alu_port_b = 32'd0;
    alu_alu_op = 4'd0;
    if (grant0) begin
      alu_port_a = port_a0;
      alu_port_b = port_b0;
      alu_alu_op = alu_op0;
    end else if (grant1) begin
      alu_port_a = port_a1;
      alu_port_b = port_b1;
      alu_alu_op = alu_op1;
    end
  end

  // Next-state logic. Everything holds under stall, which lets a pending
  // response survive the freeze. An idle cycle drops the valids but keeps
  // the last result visible. lastWinner stores the index of the winner.
  always_comb begin
    lastWinner_d = lastWinner_q;
    wait1_d      = wait1_q;
    rspValid0_d  = rspValid0_q;
    rspValid1_d  = rspValid1_q;
    rspData_d    = rspData_q;
    rspV_d       = rspV_q;
    rspN_d       = rspN_q;
    rspZ_d       = rspZ_q;
    if (!stall) begin
      if (grant0 || grant1) begin
        rspValid0_d  = grant0;
        rspValid1_d  = grant1;
        rspData_d    = alu_port_o;
        rspV_d       = alu_v_flag;
        rspN_d       = alu_n_flag;
        rspZ_d       = alu_z_flag;
        lastWinner_d = grant1;
      end else begin
        rspValid0_d = 1'b0;
        rspValid1_d = 1'b0;
      end
      // Requester 1 starvation count saturates at the limit.
      if (grant1 || !req1) begin
        wait1_d = '0;
      end else if (wait1_q != STARVE_MAX) begin
        wait1_d = wait1_q + WAIT_W'(1);
      end
    end
  end

  // State registers; reset makes requester 0 the winner of the first tie.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lastWinner_q <= 1'b1;
      wait1_q      <= '0;
      rspValid0_q  <= 1'b0;
      rspValid1_q  <= 1'b0;
      rspData_q    <= 32'd0;
      rspV_q       <= 1'b0;
      rspN_q       <= 1'b0;
      rspZ_q       <= 1'b0;
    end else begin
      lastWinner_q <= lastWinner_d;
      wait1_q      <= wait1_d;
      rspValid0_q  <= rspValid0_d;
      rspValid1_q  <= rspValid1_d;
      rspData_q    <= rspData_d;
      rspV_q       <= rspV_d;
      rspN_q       <= rspN_d;
      rspZ_q       <= rspZ_d;
    end
  end

  assign rsp_valid0 = rspValid0_q;
  assign rsp_valid1 = rspValid1_q;
  assign rsp_o      = rspData_q;
  assign rsp_v      = rspV_q;
  assign rsp_n      = rspN_q;
  assign rsp_z      = rspZ_q;

endmodule
